// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment scan driver
// Optional LZB_EN: leading-zero blanking mask computed at load.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     blink,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]            SEG_OFF    = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;
  localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0]         SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           bcnt;
  logic                    phase_on;
  logic [3:0]              shadow_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   shadow_b;
  logic                    lzb_hit;
  logic                    blank;
  logic [6:0]              drive_seg;
  logic [NUM_DIGITS-1:0]   drive_an;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001101;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = SEG_OFF;
    endcase
  endfunction

  // The display only ever reads the shadow, so a load never tears a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow_d[k] <= 4'd0;
      shadow_b <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow_d[k] <= digits[4*k +: 4];
      shadow_b <= blink;
    end
  end

`ifdef LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic [NUM_DIGITS-1:0] lzb_next;
  logic                  lzb_run;

  always_comb begin
    lzb_next = '0;
    lzb_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lzb_run     = lzb_run & (digits[4*k +: 4] == 4'd0);
      lzb_next[k] = lzb_run;
    end
  end

  // Reset mask matches the all-zero reset shadow: every digit but 0 blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lzb_mask <= ~NUM_DIGITS'(1);
    else if (load) lzb_mask <= lzb_next;
  end

  assign lzb_hit = lzb_mask[idx];
`else
  assign lzb_hit = 1'b0;
`endif

  assign blank     = lzb_hit | (!phase_on & shadow_b[idx]);
  assign drive_seg = blank ? SEG_OFF : decode(shadow_d[idx]);
  assign drive_an  = ~(NUM_DIGITS'(1) << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      phase_on   <= 1'b1;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        cnt      <= '0;
        idx      <= '0;
        bcnt     <= '0;
        phase_on <= 1'b1;
        seg      <= SEG_OFF;
        an       <= AN_OFF;
      end else begin
        case (state)
          IDLE: begin
            state <= GUARD;
            cnt   <= '0;
          end
          GUARD: begin
            cnt <= cnt + 1'b1;
            // Segment pattern is frozen here for the whole DRIVE part of the slot.
            if (cnt == GUARD_LAST) begin
              state <= DRIVE;
              seg   <= drive_seg;
              an    <= drive_an;
            end
          end
          DRIVE: begin
            if (cnt == SLOT_LAST) begin
              cnt   <= '0;
              state <= GUARD;
              seg   <= SEG_OFF;
              an    <= AN_OFF;
              if (idx == IDX_LAST) begin
                idx        <= '0;
                frame_tick <= 1'b1;
                if (bcnt == BLINK_LAST) begin
                  bcnt     <= '0;
                  phase_on <= ~phase_on;
                end else begin
                  bcnt <= bcnt + 1'b1;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
